// File: rtl/lif_mon_pkg.sv
// Shared types and constants for the LIF spike-rate monitor.
// Optional peak tracking in the top is enabled by LIF_MON_PEAK_EN.
package lif_mon_pkg;

   localparam int LIF_CNT_W = 8;

   localparam logic [LIF_CNT_W-1:0] LIF_SAT_MAX = '1;

   typedef struct packed {
      logic [LIF_CNT_W-1:0] count;
      logic [LIF_CNT_W-1:0] isi;
      logic [LIF_CNT_W-1:0] peak;
   } lif_snap_t;

   function automatic logic [LIF_CNT_W-1:0] lif_sat_add1(
      input logic [LIF_CNT_W-1:0] v,
      input logic                 inc
   );
      return (inc && v != LIF_SAT_MAX) ? v + 1'b1 : v;
   endfunction

endpackage

// File: rtl/lif_sat_counter.sv
// Saturating up-counter with clear and load; clear wins over load,
// load wins over increment.
module lif_sat_counter
   import lif_mon_pkg::*;
#(
   parameter int W = LIF_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && cnt_q != MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lif_spike_monitor.sv
// Windowed spike-rate / ISI readout with a valid/ready snapshot.
// Define LIF_MON_PEAK_EN to track the peak membrane value per window.
module lif_spike_monitor
   import lif_mon_pkg::*;
#(
   parameter int WINDOW = 256,
   parameter int CNT_W  = LIF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             spike,
   input  logic [7:0]       state,
   output logic             win_valid,
   input  logic             win_ready,
   output logic [CNT_W-1:0] win_count,
   output logic [CNT_W-1:0] win_isi,
   output logic [CNT_W-1:0] win_peak,
   output logic             overrun
);

   localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] SAT = '1;

   logic              spike_q;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              seen_q;
   logic [CNT_W-1:0]  isi_last_q, isi_last_d;
   logic              win_valid_q, win_valid_d;
   logic [CNT_W-1:0]  win_count_q, win_isi_q, win_peak_q;
   logic              overrun_q;

   logic              spk_edge;
   logic              close_w;
   logic              load_w;
   logic [CNT_W-1:0]  acc_w;
   logic [CNT_W-1:0]  isi_cnt_w;
   logic [CNT_W-1:0]  count_w;
   logic [CNT_W-1:0]  peak_fit;

   assign spk_edge = spike & ~spike_q & ena;
   assign close_w  = ena && (wcnt_q == WLAST);
   assign load_w   = close_w && (!win_valid_q || win_ready);

   lif_sat_counter #(.W(CNT_W)) u_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (close_w),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (spk_edge),
      .cnt_o      (acc_w)
   );

   lif_sat_counter #(.W(CNT_W)) u_isi (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (1'b0),
      .load_i     (spk_edge),
      .load_val_i (CNT_W'(1)),
      .inc_i      (ena),
      .cnt_o      (isi_cnt_w)
   );

   // The closing window owns an edge that lands on its last cycle.
   assign count_w = (spk_edge && acc_w != SAT) ? acc_w + 1'b1 : acc_w;

   // The first edge only starts the interval; it has no ISI to report.
   assign isi_last_d = (spk_edge && seen_q) ? isi_cnt_w : isi_last_q;

   always_comb begin
      wcnt_d = wcnt_q;
      if (ena) begin
         wcnt_d = close_w ? '0 : wcnt_q + 1'b1;
      end
   end

   always_comb begin
      win_valid_d = win_valid_q;
      if (load_w) begin
         win_valid_d = 1'b1;
      end else if (win_valid_q && win_ready) begin
         win_valid_d = 1'b0;
      end
   end

`ifdef LIF_MON_PEAK_EN
   logic [7:0]  peak_q;
   logic [7:0]  peak_cur;
   logic [31:0] pk32;
   logic [31:0] max32;

   assign peak_cur = (ena && state > peak_q) ? state : peak_q;
   assign pk32     = 32'(peak_cur);
   assign max32    = 32'(SAT);
   assign peak_fit = CNT_W'((pk32 > max32) ? max32 : pk32);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         peak_q <= '0;
      end else begin
         peak_q <= close_w ? 8'd0 : peak_cur;
      end
   end
`else
   logic unused_state;
   assign unused_state = ^state;
   assign peak_fit     = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spike_q     <= 1'b0;
         wcnt_q      <= '0;
         seen_q      <= 1'b0;
         isi_last_q  <= '0;
         win_valid_q <= 1'b0;
         win_count_q <= '0;
         win_isi_q   <= '0;
         win_peak_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         spike_q     <= spike;
         wcnt_q      <= wcnt_d;
         seen_q      <= seen_q | spk_edge;
         isi_last_q  <= isi_last_d;
         win_valid_q <= win_valid_d;
         if (load_w) begin
            win_count_q <= count_w;
            win_isi_q   <= isi_last_d;
            win_peak_q  <= peak_fit;
         end
         if (close_w && !load_w) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign win_valid = win_valid_q;
   assign win_count = win_count_q;
   assign win_isi   = win_isi_q;
   assign win_peak  = win_peak_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/lif_spike_monitor.md
# lif_spike_monitor

Downstream consumer of the LIF neuron's `spike` and membrane `state` outputs. It measures firing activity over fixed windows:
- rising-edge spike count per window;
- most recent inter-spike interval (ISI);
- optionally, peak membrane value per window.

Each closed window's results go to a downstream reader through a valid/ready snapshot register. This block is the readout stage that turns raw neuron output into rate-coded data for the output pins.

## Interface
Parameters:
- `WINDOW`, 256: window length in enabled clock cycles (≥2); window counter width is `$clog2(WINDOW)`.
- `CNT_W`, 8: width of spike count, ISI and peak fields.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  measurement enable; low freezes window, count, ISI and peak state.
- `spike`  in  1  neuron spike output (level, may stay high several cycles).
- `state`  in  8  neuron membrane value.
- `win_valid`  out  1  snapshot register holds unread data.
- `win_ready`  in  1  reader accepts snapshot when high with `win_valid`.
- `win_count`  out  CNT_W  spike rising edges in the snapshot window, saturating.
- `win_isi`  out  CNT_W  last ISI at window close, saturating.
- `win_peak`  out  CNT_W  max `state` in the window (0 when feature compiled out).
- `overrun`  out  1  sticky flag: a window closed while the snapshot was still unread.

## Operation
- Edge detect:
  - `spike_q` is a register of `spike` and updates every cycle regardless of `ena`.
  - `edge = spike & ~spike_q & ena`.
  - Edges occurring while `ena` is low are lost.
- Window counter `wcnt`:
  - Counts 0..WINDOW-1 on each `ena` cycle, then wraps to 0.
  - Close cycle is `ena && wcnt == WINDOW-1`.
- Spike accumulator `acc`:
  - `acc += edge`, saturating at 2^CNT_W-1.
  - On close: the snapshot takes `acc + edge` (saturated), so an edge in the close cycle belongs to the closing window. `acc` then clears to 0.
- ISI counter `isi_cnt`:
  - Increments every `ena` cycle, saturating at 2^CNT_W-1.
  - On `edge`: `isi_last <= isi_cnt`, `isi_cnt <= 1`.
  - Spikes at cycles t and t+k give `isi_last = k`.
  - `isi_last` is 0 until the second edge after reset. The first edge loads `isi_cnt`; that value is only meaningful if ≥1 edge preceded it.
  - `isi_last` is not cleared at window close.
- Snapshot on close:
  - If `!win_valid || win_ready`: load `win_count`, `win_isi` (the `isi_last` value after this cycle's update) and `win_peak`, and set `win_valid`.
  - Otherwise: the snapshot is dropped, the held data is unchanged, and `overrun <= 1`.
- Handshake:
  - `win_valid` and data stay stable until the `win_valid && win_ready` cycle.
  - `win_valid` drops the next cycle unless a close loads new data in that same cycle; then it stays high with new data.
  - The handshake runs independently of `ena`.
- `overrun` is cleared only by reset.

## Timing
- All outputs registered. Snapshot data and `win_valid` are visible the cycle after the close cycle.
- With `ena` held high, first close is at cycle WINDOW-1 after reset release, so `win_valid` rises at cycle WINDOW.
- Reset values: `win_valid`=0, `win_count`=0, `win_isi`=0, `win_peak`=0, `overrun`=0. Internally `wcnt`, `acc`, `isi_cnt`, `isi_last`, peak accumulator and `spike_q` are all 0.
- Reset mid-window discards the partial window. It is never snapshotted.
- `ena` low for N cycles stretches the current window by N cycles.

## Configuration
- `LIF_MON_PEAK_EN` defined: a peak accumulator tracks `max(state)` over `ena` cycles.
  - The close-cycle sample is included.
  - At close it is copied to `win_peak` (when the load succeeds) and cleared to 0.
- Not defined: no peak logic; `win_peak` tied to 0.

## Structure
- Package `lif_mon_pkg`:
  - `CNT_W` default;
  - saturation-max localparam;
  - snapshot struct typedef `{count, isi, peak}`.
- One sub-module, `lif_sat_counter`: parameterised width, with increment, load and clear inputs, saturating at max. Instantiated for `acc` and `isi_cnt`.

## Test plan
Scenarios use WINDOW=16, CNT_W=8 unless stated.
- Reset, `ena`=1, no spikes, `win_ready`=1 → `win_valid` pulses at cycle 16 with count=0, isi=0; pulses repeat every 16 cycles.
- `spike` high for 3 cycles starting at cycles 2 and 7 → count=2, isi=5. Proves edge detection rather than level counting.
- Edge exactly at wcnt=15 → counted in the closing window; next window starts at 0.
- `win_ready`=0 across two closes → first snapshot held unchanged and `overrun`=1. Then `win_ready`=1 in a close cycle → new data loads with no valid gap.
- Spike every cycle-pair for 600 cycles, WINDOW=1024 → `win_count` saturates at 255. Separately, 300 cycles with no spike between edges → `win_isi`=255.
- `LIF_MON_PEAK_EN` defined, `state` ramps 0..200 then back to 10 → `win_peak`=200. Macro undefined → `win_peak`=0.
